// File: rtl/ahb_slave_resp_gen.sv
// ahb_slave_resp_gen
//   AHB slave data-phase controller. Decodes the address phase, drives a
//   simple backend request, inserts wait states and produces the
//   HREADYOUT/HRESP pair for the response mux (OKAY, two-cycle ERROR and,
//   optionally, two-cycle RETRY).
//   Optional feature macro: AHB_SLAVE_RETRY_EN (adds the RTY1/RTY2 states).
//
//   state  | meaning
//   -------+-----------------------------------------------------------------
//   IDLE   | no data phase pending; zero-wait OKAY
//   WAIT   | backend request outstanding / minimum wait not yet met
//   ERR1   | first ERROR cycle (HREADYOUT low) for an out-of-window address
//   ERR2   | second ERROR cycle (HREADYOUT high); may accept the next transfer
//   RTY1   | first RETRY cycle (HREADYOUT low), retry build only
//   RTY2   | second RETRY cycle (HREADYOUT high), retry build only
//
//   A backend failure completes in WAIT itself: that completion cycle already
//   drives HRESP=ERROR with HREADYOUT low, so it is the first ERROR cycle and
//   the FSM moves straight to ERR2. This keeps every ERROR exactly two cycles.
module ahb_slave_resp_gen #(
  parameter int ADDR_W      = 16,
  parameter int MEM_SIZE    = 1024,
  parameter int MIN_WAIT    = 0,
  parameter int RETRY_LIMIT = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              HSEL,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic              HREADY,
  input  logic              BE_ACK,
  input  logic              BE_ERR,
  output logic              HREADYOUT,
  output logic [1:0]        HRESP,
  output logic              BE_REQ,
  output logic              BE_WRITE,
  output logic [ADDR_W-1:0] BE_ADDR
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_ERR1 = 3'd2,
    S_ERR2 = 3'd3,
    S_RTY1 = 3'd4,
    S_RTY2 = 3'd5
  } state_t;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;
  localparam logic [1:0] RESP_RETRY = 2'b10;

  state_t     state;
  logic [3:0] wait_cnt;
  logic       ack_flg;
  logic       err_flg;

  logic accept;
  logic addr_bad;
  logic done;
  logic err_now;
  logic take;

  // BUSY and IDLE are treated alike, so HTRANS[0] carries no information here;
  // RETRY_LIMIT only matters when the retry states are built in.
  logic unused_htrans0;
  assign unused_htrans0 = HTRANS[0];
`ifndef AHB_SLAVE_RETRY_EN
  localparam int retry_limit_unused = RETRY_LIMIT;
`endif

  assign accept   = HSEL & HREADY & HTRANS[1];
  assign addr_bad = (32'(HADDR) >= MEM_SIZE);
  // an early ack is remembered together with its error qualifier
  assign err_now  = ack_flg ? err_flg : BE_ERR;
  assign done     = (BE_ACK | ack_flg) & (int'(wait_cnt) >= MIN_WAIT);

  // decide whether a new address phase is taken this cycle
  always_comb begin
    take = 1'b0;
    case (state)
      S_IDLE, S_ERR2: take = accept;
      S_WAIT:         take = accept & done & ~err_now;
`ifdef AHB_SLAVE_RETRY_EN
      S_RTY2:         take = accept;
`endif
      default:        take = 1'b0;
    endcase
  end

  // response decode; HREADYOUT/HRESP in WAIT follow BE_ACK directly
  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = RESP_OKAY;
    case (state)
      S_WAIT: begin
        HREADYOUT = done & ~err_now;
        HRESP     = (done & err_now) ? RESP_ERROR : RESP_OKAY;
      end
      S_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = RESP_ERROR;
      end
      S_ERR2: begin
        HREADYOUT = 1'b1;
        HRESP     = RESP_ERROR;
      end
`ifdef AHB_SLAVE_RETRY_EN
      S_RTY1: begin
        HREADYOUT = 1'b0;
        HRESP     = RESP_RETRY;
      end
      S_RTY2: begin
        HREADYOUT = 1'b1;
        HRESP     = RESP_RETRY;
      end
`endif
      default: begin
        HREADYOUT = 1'b1;
        HRESP     = RESP_OKAY;
      end
    endcase
  end

  // request stays up in WAIT until the backend has acknowledged it
  assign BE_REQ = (state == S_WAIT) & ~ack_flg;

  // state, wait counter, ack bookkeeping and address-phase latch
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state    <= S_IDLE;
      wait_cnt <= 4'd0;
      ack_flg  <= 1'b0;
      err_flg  <= 1'b0;
      BE_ADDR  <= '0;
      BE_WRITE <= 1'b0;
    end else if (take) begin
      state    <= addr_bad ? S_ERR1 : S_WAIT;
      wait_cnt <= 4'd0;
      ack_flg  <= 1'b0;
      err_flg  <= 1'b0;
      BE_ADDR  <= HADDR;
      BE_WRITE <= HWRITE;
    end else begin
      case (state)
        S_WAIT: begin
          if (done) begin
            state   <= err_now ? S_ERR2 : S_IDLE;
            ack_flg <= 1'b0;
          end else begin
            if (wait_cnt != 4'hF) wait_cnt <= wait_cnt + 4'd1;
            if (BE_ACK) begin
              ack_flg <= 1'b1;
              err_flg <= BE_ERR;
            end
`ifdef AHB_SLAVE_RETRY_EN
            if (!BE_ACK && !ack_flg && (int'(wait_cnt) == RETRY_LIMIT))
              state <= S_RTY1;
`endif
          end
        end
        S_ERR1:  state <= S_ERR2;
        S_ERR2:  state <= S_IDLE;
`ifdef AHB_SLAVE_RETRY_EN
        S_RTY1:  state <= S_RTY2;
        S_RTY2:  state <= S_IDLE;
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
